// File: rtl/bsg_manycore_pkg.sv
// Shared types and widths for the manycore remote-request path.
// The request struct is sized from the package widths, so instances of the
// issue stage must keep their coordinate and data parameters at these values.
package bsg_manycore_pkg;

    localparam int x_cord_width_gp           = 6;
    localparam int y_cord_width_gp           = 5;
    localparam int data_width_gp             = 32;
    localparam int epa_word_addr_width_gp    = 16;
    localparam int max_local_offset_width_gp = 9;

    // Local coordinate fields pulled out of a shared EVA.
    // They are sized for the largest tile group, which is 8 wide and 4 tall.
    localparam int shared_x_width_gp = 3;
    localparam int shared_y_width_gp = 2;

    typedef struct packed {
        logic [x_cord_width_gp-1:0]        x;
        logic [y_cord_width_gp-1:0]        y;
        logic [epa_word_addr_width_gp-1:0] addr;
        logic                              w;
        logic [data_width_gp-1:0]          data;
        logic [3:0]                        mask;
    } shared_eva_req_s;

    typedef enum logic [1:0] {
        fifo_empty_e = 2'd0,
        fifo_one_e   = 2'd1,
        fifo_full_e  = 2'd2
    } two_fifo_state_e;

endpackage

// File: rtl/hash_function_shared.sv
// Stripe hash for shared EVAs. The low hash_i bits form the stripe.
// The next x_width_p bits give the local X, and the y_width_p bits above them
// give the local Y. The remaining upper bits are the offset, which is placed
// above the stripe bits to form the tile-local word address.
module hash_function_shared #(
    parameter int width_p      = 32,
    parameter int hash_width_p = 4,
    parameter int x_width_p    = 3,
    parameter int y_width_p    = 2,
    parameter int addr_width_p = 16
) (
    input  logic                    en_i,
    input  logic [width_p-1:0]      eva_i,
    input  logic [hash_width_p-1:0] hash_i,
    output logic [x_width_p-1:0]    x_o,
    output logic [y_width_p-1:0]    y_o,
    output logic [addr_width_p-1:0] addr_o
);

    logic [width_p-1:0] stripe_mask;

    // Split the EVA into coordinates and a word address; outputs rest at zero when idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        x_o         = '0;
        y_o         = '0;
        addr_o      = '0;
        stripe_mask = ~({width_p{1'b1}} << hash_i);
        if (en_i) begin
            x_o    = x_width_p'(eva_i >> hash_i);
            y_o    = y_width_p'(eva_i >> (int'(hash_i) + x_width_p));
            addr_o = addr_width_p'(((eva_i >> (int'(hash_i) + x_width_p + y_width_p)) << hash_i)
                                   | (eva_i & stripe_mask));
        end
    end

endmodule

// File: rtl/shared_eva_remote_req.sv
// Issue stage for shared-EVA remote requests.
// It hashes each request into a tile-local address and relocates it by the tile-group origin.
// Requests that fall outside the tile group are dropped with an error pulse.
// Legal requests are buffered in a two-entry FIFO and released to the link
// under an outstanding-credit limit.
module shared_eva_remote_req
    import bsg_manycore_pkg::*;
#(
    parameter int width_p           = 32,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 6,
    parameter int y_cord_width_p    = 5,
    parameter int hash_width_p      = 4,
    parameter int max_out_credits_p = 16
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic                                       v_i,
    output logic                                       ready_o,
    input  logic                                       w_i,
    input  logic [width_p-1:0]                         shared_eva_i,
    input  logic [hash_width_p-1:0]                    hash_i,
    input  logic [data_width_p-1:0]                    data_i,
    input  logic [3:0]                                 mask_i,
    input  logic [x_cord_width_p-1:0]                  tg_origin_x_i,
    input  logic [y_cord_width_p-1:0]                  tg_origin_y_i,
    input  logic [x_cord_width_p-1:0]                  tg_dim_x_i,
    input  logic [y_cord_width_p-1:0]                  tg_dim_y_i,
    output logic                                       out_v_o,
    input  logic                                       out_yumi_i,
    output logic [x_cord_width_p-1:0]                  out_x_o,
    output logic [y_cord_width_p-1:0]                  out_y_o,
    output logic [epa_word_addr_width_gp-1:0]          out_addr_o,
    output logic                                       out_w_o,
    output logic [data_width_p-1:0]                    out_data_o,
    output logic [3:0]                                 out_mask_o,
    input  logic                                       credit_return_i,
    output logic [$clog2(max_out_credits_p+1)-1:0]     out_credits_o,
    output logic                                       err_o,
    output logic [width_p-1:0]                         err_eva_o
);

    localparam int xw_lp           = shared_x_width_gp;
    localparam int yw_lp           = shared_y_width_gp;
    localparam int credit_width_lp = $clog2(max_out_credits_p+1);

    localparam logic [hash_width_p-1:0]    max_hash_lp    = hash_width_p'(max_local_offset_width_gp);
    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    // ---------------- hash and bounds check ----------------
    logic [xw_lp-1:0]                  local_x;
    logic [yw_lp-1:0]                  local_y;
    logic [epa_word_addr_width_gp-1:0] local_addr;

    hash_function_shared #(
        .width_p      (width_p),
        .hash_width_p (hash_width_p),
        .x_width_p    (xw_lp),
        .y_width_p    (yw_lp),
        .addr_width_p (epa_word_addr_width_gp)
    ) u_hash (
        .en_i   (v_i),
        .eva_i  (shared_eva_i),
        .hash_i (hash_i),
        .x_o    (local_x),
        .y_o    (local_y),
        .addr_o (local_addr)
    );

    logic [x_cord_width_p-1:0] local_x_ext;
    logic [y_cord_width_p-1:0] local_y_ext;
    logic                      req_err;
    logic                      accept;
    logic                      enq;
    logic                      drop;
    logic                      deq;

    assign local_x_ext = x_cord_width_p'(local_x);
    assign local_y_ext = y_cord_width_p'(local_y);

    assign req_err = (hash_i > max_hash_lp)
                   | (local_x_ext >= tg_dim_x_i)
                   | (local_y_ext >= tg_dim_y_i);

    assign accept = v_i & ready_o;
    assign enq    = accept & ~req_err;
    assign drop   = accept &  req_err;

    // Relocate to absolute coordinates; overflow is a configuration error caught below.
    shared_eva_req_s enq_req;

    assign enq_req.x    = tg_origin_x_i + local_x_ext;
    assign enq_req.y    = tg_origin_y_i + local_y_ext;
    assign enq_req.addr = local_addr;
    assign enq_req.w    = w_i;
    assign enq_req.data = data_i;
    assign enq_req.mask = mask_i;

    // ---------------- two-entry FIFO ----------------
    two_fifo_state_e state_r, state_n;
    logic            rd_ptr_r;
    logic            wr_ptr_r;
    shared_eva_req_s mem_r [2];
    shared_eva_req_s head;
    logic            fifo_nonempty;

    assign ready_o       = (state_r != fifo_full_e);
    assign fifo_nonempty = (state_r != fifo_empty_e);
    assign head          = mem_r[rd_ptr_r];

    // FIFO occupancy state and read/write pointers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!reset_n_i) begin
            state_r  <= fifo_empty_e;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
        end else begin
            state_r <= state_n;
            if (enq) wr_ptr_r <= ~wr_ptr_r;
            if (deq) rd_ptr_r <= ~rd_ptr_r;
        end
    end

    // Occupancy transitions for enqueue and dequeue; both together keep the count.
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            fifo_empty_e: if (enq)         state_n = fifo_one_e;
            fifo_one_e: begin
                if (enq && !deq)           state_n = fifo_full_e;
                else if (deq && !enq)      state_n = fifo_empty_e;
            end
            fifo_full_e:  if (deq)         state_n = fifo_one_e;
            default:                       state_n = fifo_empty_e;
        endcase
    end

    // Entry storage is written on enqueue only.
    always_ff @(posedge clk_i) begin
        // NOTE: storage has no reset; the occupancy state alone says which entries are valid.
        if (enq) mem_r[wr_ptr_r] <= enq_req;
    end

    // ---------------- credit gate ----------------
    logic [credit_width_lp-1:0] credits_r;

    assign out_v_o       = fifo_nonempty & (credits_r != '0);
    assign deq           = out_v_o & out_yumi_i;
    assign out_credits_o = credits_r;

    // Up/down credit counter, saturating at the configured maximum.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_r <= max_credits_lp;
        end else if (deq && !credit_return_i) begin
            credits_r <= credits_r - 1'b1;
        end else if (credit_return_i && !deq && (credits_r != max_credits_lp)) begin
            credits_r <= credits_r + 1'b1;
        end
    end

    assign out_x_o    = head.x;
    assign out_y_o    = head.y;
    assign out_addr_o = head.addr;
    assign out_w_o    = head.w;
    assign out_data_o = head.data;
    assign out_mask_o = head.mask;

    // ---------------- error reporting ----------------
    // One-cycle pulse per dropped request; the EVA of the last drop is held.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_o     <= 1'b0;
            err_eva_o <= '0;
        end else begin
            err_o <= drop;
            if (drop) err_eva_o <= shared_eva_i;
        end
    end

    // ---------------- configuration and protocol checks ----------------
    logic [x_cord_width_p:0] abs_x_wide;
    logic [y_cord_width_p:0] abs_y_wide;

    assign abs_x_wide = {1'b0, tg_origin_x_i} + {1'b0, local_x_ext};
    assign abs_y_wide = {1'b0, tg_origin_y_i} + {1'b0, local_y_ext};

    a_no_coord_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        enq |-> !abs_x_wide[x_cord_width_p] && !abs_y_wide[y_cord_width_p]);

    a_no_credit_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (credit_return_i && !deq) |-> (credits_r != max_credits_lp));

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        out_yumi_i |-> out_v_o);

endmodule

// File: tb/tb_shared_eva_remote_req.sv
// Bench for shared_eva_remote_req with a two-credit limit.
// A vector table exercises the hash, relocation and error checks.
// Hand-written sequences cover back-pressure, credit exhaustion and reset while full.
module tb_shared_eva_remote_req;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic        ready_o;
    logic        w_i;
    logic [31:0] shared_eva_i;
    logic [3:0]  hash_i;
    logic [31:0] data_i;
    logic [3:0]  mask_i;
    logic [5:0]  tg_origin_x_i;
    logic [4:0]  tg_origin_y_i;
    logic [5:0]  tg_dim_x_i;
    logic [4:0]  tg_dim_y_i;
    logic        out_v_o;
    logic        out_yumi_i;
    logic [5:0]  out_x_o;
    logic [4:0]  out_y_o;
    logic [15:0] out_addr_o;
    logic        out_w_o;
    logic [31:0] out_data_o;
    logic [3:0]  out_mask_o;
    logic        credit_return_i;
    logic [1:0]  out_credits_o;
    logic        err_o;
    logic [31:0] err_eva_o;

    shared_eva_remote_req #(.max_out_credits_p(2)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .v_i             (v_i),
        .ready_o         (ready_o),
        .w_i             (w_i),
        .shared_eva_i    (shared_eva_i),
        .hash_i          (hash_i),
        .data_i          (data_i),
        .mask_i          (mask_i),
        .tg_origin_x_i   (tg_origin_x_i),
        .tg_origin_y_i   (tg_origin_y_i),
        .tg_dim_x_i      (tg_dim_x_i),
        .tg_dim_y_i      (tg_dim_y_i),
        .out_v_o         (out_v_o),
        .out_yumi_i      (out_yumi_i),
        .out_x_o         (out_x_o),
        .out_y_o         (out_y_o),
        .out_addr_o      (out_addr_o),
        .out_w_o         (out_w_o),
        .out_data_o      (out_data_o),
        .out_mask_o      (out_mask_o),
        .credit_return_i (credit_return_i),
        .out_credits_o   (out_credits_o),
        .err_o           (err_o),
        .err_eva_o       (err_eva_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [5:0]  x;
        logic [4:0]  y;
        logic [15:0] addr;
        logic        w;
        logic [31:0] data;
        logic [3:0]  mask;
    } pkt_t;

    typedef struct {
        logic [5:0]  dim_x;
        logic [4:0]  dim_y;
        logic [3:0]  hash;
        logic [31:0] eva;
        logic        w;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        exp_err;
        logic [5:0]  exp_x;
        logic [4:0]  exp_y;
        logic [15:0] exp_addr;
    } vec_t;

    pkt_t sb_q[$];
    vec_t vecs[10];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [31:0] eva, input logic [3:0] hash,
                           input logic w, input logic [31:0] data, input logic [3:0] mask);
        v_i          = 1'b1;
        shared_eva_i = eva;
        hash_i       = hash;
        w_i          = w;
        data_i       = data;
        mask_i       = mask;
    endtask

    task automatic push_exp(input logic [5:0] x, input logic [4:0] y, input logic [15:0] addr,
                            input logic w, input logic [31:0] data, input logic [3:0] mask);
        pkt_t p;
        p.x = x; p.y = y; p.addr = addr; p.w = w; p.data = data; p.mask = mask;
        sb_q.push_back(p);
    endtask

    // Compare the presented head packet against the oldest expected packet.
    task automatic take_check(input string name);
        pkt_t p;
        check({name, " out_v"}, out_v_o, 1'b1);
        if (sb_q.size() == 0) begin
            check({name, " scoreboard nonempty"}, 0, 1);
        end else begin
            p = sb_q.pop_front();
            check({name, " x"}, out_x_o, p.x);
            check({name, " y"}, out_y_o, p.y);
            check({name, " addr"}, out_addr_o, p.addr);
            check({name, " w/data/mask"}, {out_w_o, out_data_o, out_mask_o}, {p.w, p.data, p.mask});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    initial begin
        // Origin is (2,1) throughout; local x is 3 bits, local y 2 bits, max hash 9.
        // addr = ((eva >> (hash+5)) << hash) | eva[hash-1:0], truncated to 16 bits.
        vecs[0] = '{6'd4, 5'd4, 4'd0,  32'h0000_0023, 1'b0, 32'hA5A5_0001, 4'hF, 1'b0, 6'd5, 5'd1, 16'h0001};
        vecs[1] = '{6'd4, 5'd4, 4'd0,  32'h0000_0004, 1'b1, 32'h1111_1111, 4'h1, 1'b1, 6'd0, 5'd0, 16'h0000};
        vecs[2] = '{6'd4, 5'd4, 4'd0,  32'h0000_001A, 1'b1, 32'hDEAD_BEEF, 4'h3, 1'b0, 6'd4, 5'd4, 16'h0000};
        vecs[3] = '{6'd4, 5'd4, 4'd2,  32'h0000_01AE, 1'b1, 32'h0BAD_F00D, 4'hC, 1'b0, 6'd5, 5'd2, 16'h000E};
        vecs[4] = '{6'd4, 5'd4, 4'd9,  32'h0001_62AB, 1'b0, 32'h1234_5678, 4'h5, 1'b0, 6'd3, 5'd3, 16'h0AAB};
        vecs[5] = '{6'd4, 5'd4, 4'd10, 32'h0000_0023, 1'b0, 32'h0,         4'h0, 1'b1, 6'd0, 5'd0, 16'h0000};
        vecs[6] = '{6'd4, 5'd2, 4'd0,  32'h0000_0010, 1'b0, 32'h0,         4'h0, 1'b1, 6'd0, 5'd0, 16'h0000};
        vecs[7] = '{6'd4, 5'd3, 4'd0,  32'h0000_0010, 1'b1, 32'hCAFE_0007, 4'h8, 1'b0, 6'd2, 5'd3, 16'h0000};
        vecs[8] = '{6'd8, 5'd4, 4'd1,  32'hFFFF_FFFF, 1'b1, 32'h8000_0001, 4'hA, 1'b0, 6'd9, 5'd4, 16'hFFFF};
        vecs[9] = '{6'd4, 5'd4, 4'd15, 32'h0000_0000, 1'b0, 32'h0,         4'h0, 1'b1, 6'd0, 5'd0, 16'h0000};

        reset_n_i       = 1'b0;
        v_i             = 1'b0;
        w_i             = 1'b0;
        shared_eva_i    = '0;
        hash_i          = '0;
        data_i          = '0;
        mask_i          = '0;
        tg_origin_x_i   = 6'd2;
        tg_origin_y_i   = 5'd1;
        tg_dim_x_i      = 6'd4;
        tg_dim_y_i      = 5'd4;
        out_yumi_i      = 1'b0;
        credit_return_i = 1'b0;

        // Reset state.
        tick();
        tick();
        check("reset out_v", out_v_o, 1'b0);
        check("reset err", err_o, 1'b0);
        check("reset err_eva", err_eva_o, 32'h0);
        check("reset credits", out_credits_o, 2'd2);
        check("reset ready", ready_o, 1'b1);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();

        // Table-driven single requests, each fully drained before the next.
        for (int i = 0; i < 10; i++) begin
            tg_dim_x_i = vecs[i].dim_x;
            tg_dim_y_i = vecs[i].dim_y;
            set_req(vecs[i].eva, vecs[i].hash, vecs[i].w, vecs[i].data, vecs[i].mask);
            check($sformatf("vec%0d ready", i), ready_o, 1'b1);
            if (!vecs[i].exp_err)
                push_exp(vecs[i].exp_x, vecs[i].exp_y, vecs[i].exp_addr,
                         vecs[i].w, vecs[i].data, vecs[i].mask);
            tick();
            v_i = 1'b0;
            if (vecs[i].exp_err) begin
                check($sformatf("vec%0d err pulse", i), err_o, 1'b1);
                check($sformatf("vec%0d err_eva", i), err_eva_o, vecs[i].eva);
                check($sformatf("vec%0d no out_v", i), out_v_o, 1'b0);
                tick();
                check($sformatf("vec%0d err single", i), err_o, 1'b0);
            end else begin
                check($sformatf("vec%0d no err", i), err_o, 1'b0);
                take_check($sformatf("vec%0d", i));
                out_yumi_i = 1'b1;
                tick();
                out_yumi_i = 1'b0;
                check($sformatf("vec%0d drained", i), out_v_o, 1'b0);
                check($sformatf("vec%0d credit used", i), out_credits_o, 2'd1);
                credit_return_i = 1'b1;
                tick();
                credit_return_i = 1'b0;
                check($sformatf("vec%0d credit back", i), out_credits_o, 2'd2);
            end
        end
        tg_dim_x_i = 6'd4;
        tg_dim_y_i = 5'd4;

        // An error request leaves a buffered entry untouched.
        set_req(32'h23, 4'd0, 1'b0, 32'h5555_AAAA, 4'h6);
        push_exp(6'd5, 5'd1, 16'h1, 1'b0, 32'h5555_AAAA, 4'h6);
        tick();
        set_req(32'h1A, 4'd10, 1'b1, 32'h0, 4'h0);
        check("errbuf ready", ready_o, 1'b1);
        tick();
        v_i = 1'b0;
        check("errbuf err pulse", err_o, 1'b1);
        check("errbuf err_eva", err_eva_o, 32'h1A);
        check("errbuf not full", ready_o, 1'b1);
        take_check("errbuf head");
        out_yumi_i = 1'b1;
        tick();
        out_yumi_i = 1'b0;
        check("errbuf empty", out_v_o, 1'b0);
        credit_return_i = 1'b1;
        tick();
        credit_return_i = 1'b0;

        // Back-to-back requests with no consumer, then release in order under a two-credit limit.
        set_req(32'h23, 4'd0, 1'b0, 32'h0000_0001, 4'h1);
        push_exp(6'd5, 5'd1, 16'h1, 1'b0, 32'h0000_0001, 4'h1);
        check("b2b ready c1", ready_o, 1'b1);
        tick();
        set_req(32'h1A, 4'd0, 1'b1, 32'h0000_0002, 4'h2);
        push_exp(6'd4, 5'd4, 16'h0, 1'b1, 32'h0000_0002, 4'h2);
        check("b2b ready c2", ready_o, 1'b1);
        check("b2b latency", out_v_o, 1'b1);
        tick();
        set_req(32'h0001_62AB, 4'd9, 1'b0, 32'h0000_0003, 4'h3);
        check("b2b ready c3 full", ready_o, 1'b0);
        out_yumi_i = 1'b1;
        take_check("b2b first");
        tick();
        check("b2b ready after deq", ready_o, 1'b1);
        push_exp(6'd3, 5'd3, 16'hAAB, 1'b0, 32'h0000_0003, 4'h3);
        take_check("b2b second");
        tick();
        v_i        = 1'b0;
        out_yumi_i = 1'b0;
        check("credits exhausted", out_credits_o, 2'd0);
        check("no credit blocks out_v", out_v_o, 1'b0);
        check("one entry buffered", ready_o, 1'b1);
        credit_return_i = 1'b1;
        tick();
        credit_return_i = 1'b0;
        check("credit return", out_credits_o, 2'd1);
        take_check("b2b third");
        out_yumi_i      = 1'b1;
        credit_return_i = 1'b1;
        tick();
        out_yumi_i      = 1'b0;
        credit_return_i = 1'b0;
        check("same-cycle yumi+return", out_credits_o, 2'd1);
        check("b2b drained", out_v_o, 1'b0);
        credit_return_i = 1'b1;
        tick();
        credit_return_i = 1'b0;
        check("credits full again", out_credits_o, 2'd2);

        // Reset while full discards entries and restores credits.
        set_req(32'h23, 4'd0, 1'b0, 32'h0000_0010, 4'hF);
        push_exp(6'd5, 5'd1, 16'h1, 1'b0, 32'h0000_0010, 4'hF);
        tick();
        v_i = 1'b0;
        take_check("pre-reset");
        out_yumi_i = 1'b1;
        tick();
        out_yumi_i = 1'b0;
        set_req(32'h1A, 4'd0, 1'b1, 32'h0000_0011, 4'h1);
        tick();
        set_req(32'h0000_01AE, 4'd2, 1'b1, 32'h0000_0012, 4'h2);
        tick();
        v_i = 1'b0;
        check("pre-reset full", ready_o, 1'b0);
        check("pre-reset credits", out_credits_o, 2'd1);
        #2;
        reset_n_i = 1'b0;
        #1;
        sb_q.delete();
        check("reset-full out_v", out_v_o, 1'b0);
        check("reset-full ready", ready_o, 1'b1);
        check("reset-full credits", out_credits_o, 2'd2);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();
        check("post-reset out_v", out_v_o, 1'b0);
        check("post-reset credits", out_credits_o, 2'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
